// File: rtl/pair_index_checker.sv
// Checks a stream of even/odd address pairs for parity, half agreement and
// strictly incrementing index from START_IDX up to END_IDX inclusive.
module pair_index_checker #(
   parameter logic [12:0] START_IDX = 13'd3200,
   parameter logic [12:0] END_IDX   = 13'd3328
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [13:0] Q_a,
   input  logic [13:0] Q_b,
   input  logic        in_valid,
   input  logic        restart,
   output logic        in_ready,
   output logic [12:0] idx_out,
   output logic        out_valid,
   output logic [7:0]  pair_count,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code
);

   // state | meaning
   // IDLE  | waiting for the START_IDX beat, exp_idx = START_IDX
   // RUN   | sequence in progress, exp_idx = next index required
   // DONE  | END_IDX accepted cleanly; further beats ignored
   // ERR   | a check failed; err_code holds the first cause
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   localparam logic [1:0] CODE_NONE   = 2'b00;
   localparam logic [1:0] CODE_PARITY = 2'b01;
   localparam logic [1:0] CODE_HALF   = 2'b10;
   localparam logic [1:0] CODE_SEQ    = 2'b11;

   state_t      state;
   state_t      state_nxt;
   logic [12:0] exp_idx;
   logic [12:0] exp_nxt;
   logic [12:0] idx_nxt;
   logic        ov_nxt;
   logic [7:0]  cnt_nxt;
   logic [1:0]  code_nxt;

   logic        accept;
   logic        parity_ok;
   logic        halves_ok;
   logic        seq_ok;
   logic [12:0] beat_idx;

   assign in_ready  = (state == IDLE) || (state == RUN);
   assign done      = (state == DONE);
   assign err       = (state == ERR);
   assign accept    = in_valid && in_ready;
   assign beat_idx  = Q_a[13:1];
   assign parity_ok = !Q_a[0] && Q_b[0];
   assign halves_ok = (Q_a[13:1] == Q_b[13:1]);
   assign seq_ok    = (beat_idx == exp_idx);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         exp_idx    <= START_IDX;
         idx_out    <= 13'd0;
         out_valid  <= 1'b0;
         pair_count <= 8'd0;
         err_code   <= CODE_NONE;
      end else begin
         state      <= state_nxt;
         exp_idx    <= exp_nxt;
         idx_out    <= idx_nxt;
         out_valid  <= ov_nxt;
         pair_count <= cnt_nxt;
         err_code   <= code_nxt;
      end
   end

   // restart outranks any beat presented in the same cycle
   always_comb begin
      state_nxt = state;
      exp_nxt   = exp_idx;
      idx_nxt   = idx_out;
      ov_nxt    = 1'b0;
      cnt_nxt   = pair_count;
      code_nxt  = err_code;
      if (restart) begin
         state_nxt = IDLE;
         exp_nxt   = START_IDX;
         cnt_nxt   = 8'd0;
         code_nxt  = CODE_NONE;
      end else if (accept) begin
         if (!parity_ok) begin
            state_nxt = ERR;
            code_nxt  = CODE_PARITY;
         end else if (!halves_ok) begin
            state_nxt = ERR;
            code_nxt  = CODE_HALF;
         end else if (!seq_ok) begin
            state_nxt = ERR;
            code_nxt  = CODE_SEQ;
         end else begin
            idx_nxt = beat_idx;
            ov_nxt  = 1'b1;
            if (pair_count != 8'hFF) begin
               cnt_nxt = pair_count + 8'd1;
            end
            // exp_idx parks at END_IDX so it never steps past the range
            if (beat_idx == END_IDX) begin
               state_nxt = DONE;
            end else begin
               state_nxt = RUN;
               exp_nxt   = exp_idx + 13'd1;
            end
         end
      end
   end

endmodule
